// File: rtl/s27_bist.sv
// -----------------------------------------------------------------------------
// s27_bist
//
// Built-in self-test driver for the ISCAS-89 s27 benchmark. Drives the s27
// primary inputs G0..G3, observes G17, and runs this sequence:
//   IDLE -> INIT1 -> INIT2 -> RUN (NUM_PATTERNS cycles) -> DONE
// INIT1/INIT2 apply two flush patterns (1110, 0111 on G0..G3) that force the
// s27 state flops G5,G6,G7 to 000 from any start value. RUN applies the low
// nibble of an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) each cycle and
// compacts G17 into a 16-bit CRC-CCITT serial signature. DONE reports
// PASS = (SIG == GOLDEN_SIG).
//
// Ports
//   CK           clock, rising edge
//   RST          asynchronous active-high reset
//   START        start request (IDLE or DONE only)
//   G17          s27 output under observation
//   G0..G3       registered drives to s27 inputs
//   BUSY         high in INIT1, INIT2, RUN
//   DONE         high in DONE
//   PASS         signature compare result, valid while DONE is high
//   SIG          current signature register
//   dbg_state_o  FSM state, for checkers
//
// Start/done protocol: START is a request sampled on each rising edge; it is
// accepted only when BUSY is low (IDLE or DONE) and ignored otherwise. An
// accepted request raises BUSY on that edge; BUSY falls on the same edge DONE
// rises, and DONE stays high until the next accepted request or reset.
// -----------------------------------------------------------------------------
module s27_bist #(
  parameter int unsigned NUM_PATTERNS = 255,
  parameter logic [7:0]  SEED         = 8'h01,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        START,
  input  logic        G17,
  output logic        G0,
  output logic        G1,
  output logic        G2,
  output logic        G3,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [15:0] SIG,
  output logic [2:0]  dbg_state_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT1 = 3'd1;
  localparam logic [2:0] ST_INIT2 = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // An all-zero seed would lock the LFSR, so it is substituted.
  localparam logic [7:0]  SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [15:0] CNT_LAST = 16'(NUM_PATTERNS - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  pins_q, pins_d;   // {G0,G1,G2,G3}
  logic [15:0] sig_q, sig_d;
  logic        pass_q, pass_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  lfsr_step;
  logic [15:0] sig_step;

  assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign sig_step  = {sig_q[14:0], 1'b0} ^ ((sig_q[15] ^ G17) ? 16'h1021 : 16'h0000);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    pins_d  = pins_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d = ST_INIT1;
          sig_d   = 16'h0000;
          lfsr_d  = SEED_EFF;
          cnt_d   = 16'h0000;
          pins_d  = 4'b1110;
          pass_d  = 1'b0;
        end
      end
      ST_INIT1: begin
        state_d = ST_INIT2;
        pins_d  = 4'b0111;
      end
      ST_INIT2: begin
        state_d = ST_RUN;
        pins_d  = {lfsr_q[0], lfsr_q[1], lfsr_q[2], lfsr_q[3]};
      end
      ST_RUN: begin
        sig_d  = sig_step;
        lfsr_d = lfsr_step;
        cnt_d  = cnt_q + 16'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          pins_d  = 4'b0000;
          // Compare the signature that includes this final sample.
          pass_d  = (sig_step == GOLDEN_SIG);
        end else begin
          pins_d  = {lfsr_step[0], lfsr_step[1], lfsr_step[2], lfsr_step[3]};
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_INIT1) || (state_d == ST_INIT2) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      lfsr_q  <= SEED_EFF;
      cnt_q   <= 16'h0000;
      pins_q  <= 4'b0000;
      sig_q   <= 16'h0000;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      pins_q  <= pins_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign G0          = pins_q[3];
  assign G1          = pins_q[2];
  assign G2          = pins_q[1];
  assign G3          = pins_q[0];
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign PASS        = pass_q;
  assign SIG         = sig_q;
  assign dbg_state_o = state_q;

endmodule
